// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency IF lookup,
// EX-stage resolve/mispredict detection, single-port training and statistics.
module branch_predictor #(
    parameter int IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 32 - IDX_BITS - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [31:0]        branch_cnt_q, branch_cnt_d;
    logic [31:0]        mispred_cnt_q, mispred_cnt_d;

    logic [IDX_BITS-1:0] if_idx_s, ex_idx_s;
    logic [TAG_W-1:0]    if_tag_s, ex_tag_s;
    logic                if_hit_s, ex_hit_s, upd_s;
    logic                wr_en_s;
    logic [31:0]         wr_target_s;
    logic [1:0]          wr_ctr_s;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case ({taken, ctr})
            3'b1_11: nxt = 2'b11;
            3'b0_00: nxt = 2'b00;
            3'b1_00, 3'b1_01, 3'b1_10: nxt = ctr + 2'd1;
            3'b0_01, 3'b0_10, 3'b0_11: nxt = ctr - 2'd1;
            default: nxt = 2'b01;
        endcase
        return nxt;
    endfunction

    // IF lookup: reads only the registered table, so same-cycle updates are not bypassed
    always_comb begin
        if_idx_s    = if_pc[IDX_BITS+1:2];
        if_tag_s    = if_pc[31:IDX_BITS+2];
        if_hit_s    = valid_q[if_idx_s] && (tag_q[if_idx_s] == if_tag_s);
        pred_taken  = if_hit_s && ctr_q[if_idx_s][1];
        if (pred_taken) begin
            pred_target = target_q[if_idx_s];
        end else begin
            pred_target = if_pc + 32'd4;
        end
    end

    // EX resolve: flush request and corrected PC
    always_comb begin
        upd_s      = ex_valid && ex_branch;
        mispredict = upd_s && ((ex_taken != ex_pred_taken) ||
                               (ex_taken && (ex_target != ex_pred_target)));
        if (ex_taken) begin
            redirect_pc = ex_target;
        end else begin
            redirect_pc = ex_pc + 32'd4;
        end
    end

    // Table write selection: train on hit, allocate on taken miss
    always_comb begin
        ex_idx_s    = ex_pc[IDX_BITS+1:2];
        ex_tag_s    = ex_pc[31:IDX_BITS+2];
        ex_hit_s    = valid_q[ex_idx_s] && (tag_q[ex_idx_s] == ex_tag_s);
        wr_en_s     = 1'b0;
        wr_target_s = target_q[ex_idx_s];
        wr_ctr_s    = ctr_q[ex_idx_s];
        if (upd_s && ex_hit_s) begin
            wr_en_s  = 1'b1;
            wr_ctr_s = ctr_step(ctr_q[ex_idx_s], ex_taken);
            if (ex_taken) begin
                wr_target_s = ex_target;
            end else begin
                wr_target_s = target_q[ex_idx_s];
            end
        end else if (upd_s && ex_taken) begin
            wr_en_s     = 1'b1;
            wr_target_s = ex_target;
            wr_ctr_s    = 2'b10;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Table storage with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (wr_en_s) begin
            valid_q[ex_idx_s]  <= 1'b1;
            tag_q[ex_idx_s]    <= ex_tag_s;
            target_q[ex_idx_s] <= wr_target_s;
            ctr_q[ex_idx_s]    <= wr_ctr_s;
        end
    end

    // Statistics next-state
    always_comb begin
        if (upd_s) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end else begin
            branch_cnt_d = branch_cnt_q;
        end
        if (mispredict) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end else begin
            mispred_cnt_d = mispred_cnt_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q  <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a reference table model computes
// expected outputs per cycle, queued at drive time and compared at negedge.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pt;
        logic [31:0] ptg;
        logic        mp;
        logic [31:0] rpc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic        m_valid [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_tgt   [64];
    logic [1:0]  m_ctr   [64];
    logic [31:0] m_bc, m_mc;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 24'd0;
            m_tgt[i]   = 32'd0;
            m_ctr[i]   = 2'b01;
        end
        m_bc = 32'd0;
        m_mc = 32'd0;
    endtask

    function automatic logic model_hit(input logic [31:0] pc);
        return m_valid[pc[7:2]] && (m_tag[pc[7:2]] == pc[31:8]);
    endfunction

    function automatic logic model_pt(input logic [31:0] pc);
        return model_hit(pc) && m_ctr[pc[7:2]][1];
    endfunction

    function automatic logic [31:0] model_ptg(input logic [31:0] pc);
        return model_pt(pc) ? m_tgt[pc[7:2]] : pc + 32'd4;
    endfunction

    // One cycle: drive, queue expectation, compare at negedge, advance model at posedge
    task automatic step(input logic [31:0] pc_if, input logic ev, input logic eb,
                        input logic [31:0] epc, input logic et, input logic [31:0] etg,
                        input logic ept, input logic [31:0] eptg);
        exp_t e, o;
        logic upd, mp, hit;
        logic [5:0] idx;
        if_pc = pc_if; ex_valid = ev; ex_branch = eb; ex_pc = epc;
        ex_taken = et; ex_target = etg; ex_pred_taken = ept; ex_pred_target = eptg;
        upd   = ev && eb;
        mp    = upd && ((et != ept) || (et && (etg != eptg)));
        e.pt  = model_pt(pc_if);
        e.ptg = model_ptg(pc_if);
        e.mp  = mp;
        e.rpc = et ? etg : epc + 32'd4;
        e.bc  = m_bc;
        e.mc  = m_mc;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            o = sb_q.pop_front();
            check_eq("pred_taken", {31'd0, pred_taken}, {31'd0, o.pt});
            check_eq("pred_target", pred_target, o.ptg);
            check_eq("mispredict", {31'd0, mispredict}, {31'd0, o.mp});
            check_eq("redirect_pc", redirect_pc, o.rpc);
            check_eq("branch_cnt", branch_cnt, o.bc);
            check_eq("mispred_cnt", mispred_cnt, o.mc);
        end
        @(posedge clk);
        idx = epc[7:2];
        hit = model_hit(epc);
        if (upd) begin
            if (hit) begin
                if (et) begin
                    m_ctr[idx] = (m_ctr[idx] == 2'b11) ? 2'b11 : m_ctr[idx] + 2'd1;
                    m_tgt[idx] = etg;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] == 2'b00) ? 2'b00 : m_ctr[idx] - 2'd1;
                end
            end else if (et) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = epc[31:8];
                m_tgt[idx]   = etg;
                m_ctr[idx]   = 2'b10;
            end
            m_bc = m_bc + 32'd1;
        end
        if (mp) m_mc = m_mc + 32'd1;
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        step(pc, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd4);
    endtask

    // Resolve a branch carrying the prediction the table would have given it
    task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        step(pc, 1'b1, 1'b1, pc, t, tgt, model_pt(pc), model_ptg(pc));
    endtask

    initial begin
        rst_n = 1'b0;
        if_pc = 32'h100; ex_valid = 1'b0; ex_branch = 1'b0; ex_pc = 32'd0;
        ex_taken = 1'b0; ex_target = 32'd0; ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
        model_reset();
        #2;
        check_eq("rst_pt", {31'd0, pred_taken}, 32'd0);
        check_eq("rst_ptg", pred_target, 32'h104);
        check_eq("rst_bc", branch_cnt, 32'd0);
        check_eq("rst_mc", mispred_cnt, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        lookup(32'h100);
        resolve(32'h100, 1'b1, 32'h40);
        lookup(32'h100);
        check_eq("alloc_ptg", pred_target, 32'h40);
        check_eq("alloc_mc", mispred_cnt, 32'd1);

        // Hysteresis 10 -> 01 -> 10 -> 11 -> 10
        resolve(32'h100, 1'b0, 32'h40);
        lookup(32'h100);
        check_eq("hyst_nt", {31'd0, pred_taken}, 32'd0);
        resolve(32'h100, 1'b1, 32'h40);
        resolve(32'h100, 1'b1, 32'h40);
        resolve(32'h100, 1'b0, 32'h40);
        lookup(32'h100);
        check_eq("hyst_t", {31'd0, pred_taken}, 32'd1);

        for (int i = 0; i < 5; i++) resolve(32'h100, 1'b1, 32'h40);
        lookup(32'h100);
        for (int i = 0; i < 5; i++) resolve(32'h100, 1'b0, 32'h40);
        lookup(32'h100);
        resolve(32'h100, 1'b1, 32'h40);
        lookup(32'h100);
        check_eq("sat_low", {31'd0, pred_taken}, 32'd0);

        resolve(32'h200, 1'b1, 32'h80);
        lookup(32'h100);
        check_eq("alias_miss", pred_target, 32'h104);
        lookup(32'h200);
        check_eq("alias_hit", pred_target, 32'h80);
        resolve(32'h200, 1'b1, 32'h90);
        lookup(32'h200);

        resolve(32'h300, 1'b1, 32'h500);
        lookup(32'h300);
        check_eq("conflict_next", {31'd0, pred_taken}, 32'd1);

        step(32'h400, 1'b0, 1'b1, 32'h400, 1'b1, 32'h10, 1'b0, 32'h404);
        step(32'h400, 1'b1, 1'b0, 32'h400, 1'b1, 32'h10, 1'b0, 32'h404);
        lookup(32'h400);

        // Asynchronous reset in the middle of the low phase
        @(negedge clk);
        if_pc = 32'h300;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("mid_rst_pt", {31'd0, pred_taken}, 32'd0);
        check_eq("mid_rst_bc", branch_cnt, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        lookup(32'h200);
        lookup(32'h300);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] pcs [4];
            logic [31:0] p, q;
            pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h104; pcs[3] = 32'h1100;
            p = pcs[$urandom_range(0, 3)];
            q = pcs[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) begin
                step(q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), p,
                     1'($urandom_range(0, 1)), {24'd0, 8'($urandom_range(0, 3)) << 4},
                     1'($urandom_range(0, 1)), {24'd0, 8'($urandom_range(0, 3)) << 4});
            end else begin
                if_pc = q;
                resolve(p, 1'($urandom_range(0, 1)), {24'd0, 8'($urandom_range(0, 3)) << 4});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
